control_pipeline: RTL and testbench

- Successor to the single-cycle main control decoder for the 5-stage MIPS pipeline.
- Decodes the ID-stage opcode into the same control signal set.
- Carries each signal through registered ID/EX, EX/MEM and MEM/WB control stages with the destination register address.
- Detects load-use hazards and inserts bubbles.
- Handles branch/jump flush and flags illegal opcodes.

---
 rtl/control_pipeline.sv | 254 +++++++++++++++++++++++++
 tb/tb_control_pipeline.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - MIPS main control decoder with registered EX/MEM/WB control stages and load-use hazard detection
module control_pipeline #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit ENABLE_HAZARD  = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  logic [5:0]                id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      flush,
    output logic                      id_jump,
    output logic                      load_use_stall,
    output logic                      illegal_opcode,
    output logic [1:0]                ex_alu_opcode,
    output logic                      ex_alu_source,
    output logic                      ex_shift_upper,
    output logic                      ex_branch_eq,
    output logic                      ex_branch_ne,
    output logic                      mem_memory_read,
    output logic                      mem_memory_write,
    output logic                      wb_register_write,
    output logic                      wb_memory_to_register,
    output logic [REG_ADDR_WIDTH-1:0] wb_write_reg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ID-stage decode results
    logic [1:0]                dec_alu_opcode;
    logic                      dec_alu_source;
    logic                      dec_shift_upper;
    logic                      dec_branch_eq;
    logic                      dec_branch_ne;
    logic                      dec_memory_read;
    logic                      dec_memory_write;
    logic                      dec_register_write;
    logic                      dec_memory_to_register;
    logic                      dec_register_destination;
    logic                      dec_jump;
    logic                      dec_legal;
    logic                      dec_uses_rt;
    logic [REG_ADDR_WIDTH-1:0] dec_write_reg;

    // EX stage control
    logic [1:0]                ex_alu_opcode_q, ex_alu_opcode_d;
    logic                      ex_alu_source_q, ex_alu_source_d;
    logic                      ex_shift_upper_q, ex_shift_upper_d;
    logic                      ex_branch_eq_q, ex_branch_eq_d;
    logic                      ex_branch_ne_q, ex_branch_ne_d;
    logic                      ex_memory_read_q, ex_memory_read_d;
    logic                      ex_memory_write_q, ex_memory_write_d;
    logic                      ex_register_write_q, ex_register_write_d;
    logic                      ex_memory_to_register_q, ex_memory_to_register_d;
    logic [REG_ADDR_WIDTH-1:0] ex_write_reg_q, ex_write_reg_d;
    logic                      illegal_q, illegal_d;

    // MEM stage control
    logic                      mem_memory_read_q, mem_memory_read_d;
    logic                      mem_memory_write_q, mem_memory_write_d;
    logic                      mem_register_write_q, mem_register_write_d;
    logic                      mem_memory_to_register_q, mem_memory_to_register_d;
    logic [REG_ADDR_WIDTH-1:0] mem_write_reg_q, mem_write_reg_d;

    // WB stage control
    logic                      wb_register_write_q, wb_register_write_d;
    logic                      wb_memory_to_register_q, wb_memory_to_register_d;
    logic [REG_ADDR_WIDTH-1:0] wb_write_reg_q, wb_write_reg_d;

    // Hazard and load qualifiers
    logic rs_match;
    logic rt_match;
    logic hazard_hit;
    logic load_id;
    logic load_instr;

    // Main control decode; illegal opcodes collapse to a bubble
    always_comb begin
        dec_alu_opcode           = 2'b10;
        dec_alu_source           = 1'b0;
        dec_shift_upper          = 1'b0;
        dec_branch_eq            = 1'b0;
        dec_branch_ne            = 1'b0;
        dec_memory_read          = 1'b0;
        dec_memory_write         = 1'b0;
        dec_register_write       = 1'b1;
        dec_memory_to_register   = 1'b0;
        dec_register_destination = 1'b1;
        dec_jump                 = 1'b0;
        dec_legal                = 1'b1;
        dec_uses_rt              = 1'b0;
        case (id_opcode)
            OP_RTYPE: begin
                dec_uses_rt = 1'b1;
            end
            OP_LW: begin
                dec_memory_read          = 1'b1;
                dec_memory_to_register   = 1'b1;
                dec_alu_source           = 1'b1;
                dec_alu_opcode           = 2'b00;
                dec_register_destination = 1'b0;
            end
            OP_SW: begin
                dec_memory_write   = 1'b1;
                dec_alu_source     = 1'b1;
                dec_alu_opcode     = 2'b00;
                dec_register_write = 1'b0;
                dec_uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                dec_branch_eq      = 1'b1;
                dec_alu_opcode     = 2'b01;
                dec_register_write = 1'b0;
                dec_uses_rt        = 1'b1;
            end
            OP_BNE: begin
                dec_branch_ne      = 1'b1;
                dec_alu_opcode     = 2'b01;
                dec_register_write = 1'b0;
                dec_uses_rt        = 1'b1;
            end
            OP_ADDI, OP_ORI: begin
                dec_alu_source           = 1'b1;
                dec_alu_opcode           = 2'b00;
                dec_register_destination = 1'b0;
            end
            OP_LUI: begin
                dec_alu_source           = 1'b1;
                dec_shift_upper          = 1'b1;
                dec_alu_opcode           = 2'b00;
                dec_register_destination = 1'b0;
            end
            OP_J: begin
                dec_jump           = 1'b1;
                dec_register_write = 1'b0;
            end
            default: begin
                dec_legal                = 1'b0;
                dec_alu_opcode           = 2'b00;
                dec_register_write       = 1'b0;
                dec_register_destination = 1'b0;
            end
        endcase
        dec_write_reg = dec_register_destination ? id_rd : id_rt;
    end

    // Load-use detection: a load in EX whose target is read by the ID instruction; r0 never hazards
    always_comb begin
        rs_match   = (ex_write_reg_q == id_rs);
        rt_match   = dec_uses_rt && (ex_write_reg_q == id_rt);
        hazard_hit = ENABLE_HAZARD && reset_n && id_valid
                     && ex_memory_read_q && ex_register_write_q
                     && (ex_write_reg_q != '0) && (rs_match || rt_match);
    end

    assign load_use_stall = hazard_hit;
    assign id_jump        = dec_jump && id_valid && !flush && reset_n;

    // Next-state for the control stages; EX takes a bubble on invalid, flush or stall
    always_comb begin
        load_id    = id_valid && !flush && !hazard_hit;
        load_instr = load_id && dec_legal;

        ex_alu_opcode_d         = load_instr ? dec_alu_opcode : 2'b00;
        ex_alu_source_d         = load_instr && dec_alu_source;
        ex_shift_upper_d        = load_instr && dec_shift_upper;
        ex_branch_eq_d          = load_instr && dec_branch_eq;
        ex_branch_ne_d          = load_instr && dec_branch_ne;
        ex_memory_read_d        = load_instr && dec_memory_read;
        ex_memory_write_d       = load_instr && dec_memory_write;
        ex_register_write_d     = load_instr && dec_register_write;
        ex_memory_to_register_d = load_instr && dec_memory_to_register;
        ex_write_reg_d          = load_instr ? dec_write_reg : '0;
        illegal_d               = load_id && !dec_legal;

        mem_memory_read_d        = ex_memory_read_q;
        mem_memory_write_d       = ex_memory_write_q;
        mem_register_write_d     = ex_register_write_q;
        mem_memory_to_register_d = ex_memory_to_register_q;
        mem_write_reg_d          = ex_write_reg_q;

        wb_register_write_d     = mem_register_write_q;
        wb_memory_to_register_d = mem_memory_to_register_q;
        wb_write_reg_d          = mem_write_reg_q;
    end

    // Stage registers; reset flushes every stage to a bubble
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_alu_opcode_q          <= 2'b00;
            ex_alu_source_q          <= 1'b0;
            ex_shift_upper_q         <= 1'b0;
            ex_branch_eq_q           <= 1'b0;
            ex_branch_ne_q           <= 1'b0;
            ex_memory_read_q         <= 1'b0;
            ex_memory_write_q        <= 1'b0;
            ex_register_write_q      <= 1'b0;
            ex_memory_to_register_q  <= 1'b0;
            ex_write_reg_q           <= '0;
            illegal_q                <= 1'b0;
            mem_memory_read_q        <= 1'b0;
            mem_memory_write_q       <= 1'b0;
            mem_register_write_q     <= 1'b0;
            mem_memory_to_register_q <= 1'b0;
            mem_write_reg_q          <= '0;
            wb_register_write_q      <= 1'b0;
            wb_memory_to_register_q  <= 1'b0;
            wb_write_reg_q           <= '0;
        end else begin
            ex_alu_opcode_q          <= ex_alu_opcode_d;
            ex_alu_source_q          <= ex_alu_source_d;
            ex_shift_upper_q         <= ex_shift_upper_d;
            ex_branch_eq_q           <= ex_branch_eq_d;
            ex_branch_ne_q           <= ex_branch_ne_d;
            ex_memory_read_q         <= ex_memory_read_d;
            ex_memory_write_q        <= ex_memory_write_d;
            ex_register_write_q      <= ex_register_write_d;
            ex_memory_to_register_q  <= ex_memory_to_register_d;
            ex_write_reg_q           <= ex_write_reg_d;
            illegal_q                <= illegal_d;
            mem_memory_read_q        <= mem_memory_read_d;
            mem_memory_write_q       <= mem_memory_write_d;
            mem_register_write_q     <= mem_register_write_d;
            mem_memory_to_register_q <= mem_memory_to_register_d;
            mem_write_reg_q          <= mem_write_reg_d;
            wb_register_write_q      <= wb_register_write_d;
            wb_memory_to_register_q  <= wb_memory_to_register_d;
            wb_write_reg_q           <= wb_write_reg_d;
        end
    end

    assign illegal_opcode        = illegal_q;
    assign ex_alu_opcode         = ex_alu_opcode_q;
    assign ex_alu_source         = ex_alu_source_q;
    assign ex_shift_upper        = ex_shift_upper_q;
    assign ex_branch_eq          = ex_branch_eq_q;
    assign ex_branch_ne          = ex_branch_ne_q;
    assign mem_memory_read       = mem_memory_read_q;
    assign mem_memory_write      = mem_memory_write_q;
    assign wb_register_write     = wb_register_write_q;
    assign wb_memory_to_register = wb_memory_to_register_q;
    assign wb_write_reg          = wb_write_reg_q;

endmodule

// File: tb/tb_control_pipeline.sv
// tb/tb_control_pipeline.sv - self-checking bench for control_pipeline
module tb_control_pipeline;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000, RT = 6'b000000, LUI = 6'b001111, ORI = 6'b001101;
    localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

    typedef struct packed {
        logic [1:0] aluop;
        logic alusrc, shup, beq, bne, mrd, mwr, rw, m2r;
        logic [4:0] wr;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = 6'd0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
    logic       flush = 1'b0;

    logic       id_jump, load_use_stall, illegal_opcode;
    logic [1:0] ex_alu_opcode;
    logic       ex_alu_source, ex_shift_upper, ex_branch_eq, ex_branch_ne;
    logic       mem_memory_read, mem_memory_write, wb_register_write, wb_memory_to_register;
    logic [4:0] wb_write_reg;

    logic       n_id_jump, n_load_use_stall, n_illegal_opcode;
    logic [1:0] n_ex_alu_opcode;
    logic       n_ex_alu_source, n_ex_shift_upper, n_ex_branch_eq, n_ex_branch_ne;
    logic       n_mem_memory_read, n_mem_memory_write, n_wb_register_write, n_wb_memory_to_register;
    logic [4:0] n_wb_write_reg;

    int checks = 0;
    int failures = 0;

    ctl_t        m_ex[2], m_mem[2], m_wb[2];
    bit          m_ill[2];
    bit          exp_jump, exp_stall[2], obs_jump[2], obs_stall[2];
    logic [15:0] exp_reg[2], obs_reg[2];

    control_pipeline #(.REG_ADDR_WIDTH(5), .ENABLE_HAZARD(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .id_jump(id_jump), .load_use_stall(load_use_stall), .illegal_opcode(illegal_opcode),
        .ex_alu_opcode(ex_alu_opcode), .ex_alu_source(ex_alu_source), .ex_shift_upper(ex_shift_upper),
        .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
        .mem_memory_read(mem_memory_read), .mem_memory_write(mem_memory_write),
        .wb_register_write(wb_register_write), .wb_memory_to_register(wb_memory_to_register),
        .wb_write_reg(wb_write_reg)
    );

    control_pipeline #(.REG_ADDR_WIDTH(5), .ENABLE_HAZARD(1'b0)) dut_nh (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .id_jump(n_id_jump), .load_use_stall(n_load_use_stall), .illegal_opcode(n_illegal_opcode),
        .ex_alu_opcode(n_ex_alu_opcode), .ex_alu_source(n_ex_alu_source), .ex_shift_upper(n_ex_shift_upper),
        .ex_branch_eq(n_ex_branch_eq), .ex_branch_ne(n_ex_branch_ne),
        .mem_memory_read(n_mem_memory_read), .mem_memory_write(n_mem_memory_write),
        .wb_register_write(n_wb_register_write), .wb_memory_to_register(n_wb_memory_to_register),
        .wb_write_reg(n_wb_write_reg)
    );

    always #5 clk = ~clk;

    // Reference: the control set each opcode asks for, written out per instruction class
    function automatic void ref_decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                                       output ctl_t c, output bit jmp, output bit legal, output bit uses_rt);
        bit dest_rt;
        c = '0; jmp = 0; legal = 1; uses_rt = 0; dest_rt = 0;
        case (op)
            RT:   begin c.aluop = 2'b10; c.rw = 1; uses_rt = 1; end
            LW:   begin c.mrd = 1; c.m2r = 1; c.alusrc = 1; c.rw = 1; dest_rt = 1; end
            SW:   begin c.mwr = 1; c.alusrc = 1; uses_rt = 1; end
            BEQ:  begin c.aluop = 2'b01; c.beq = 1; uses_rt = 1; end
            BNE:  begin c.aluop = 2'b01; c.bne = 1; uses_rt = 1; end
            ADDI: begin c.alusrc = 1; c.rw = 1; dest_rt = 1; end
            ORI:  begin c.alusrc = 1; c.rw = 1; dest_rt = 1; end
            LUI:  begin c.alusrc = 1; c.shup = 1; c.rw = 1; dest_rt = 1; end
            JMP:  begin c.aluop = 2'b10; jmp = 1; end
            default: legal = 0;
        endcase
        if (legal) c.wr = dest_rt ? rt : rd;
    endfunction

    // Drive one ID slot, record combinational outputs, advance the model, record stage outputs
    task automatic cycle(input bit v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input bit fl, input bit rn);
        ctl_t dc;
        bit jmp, legal, urt, take;
        @(negedge clk);
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl; reset_n = rn;
        #1;
        ref_decode(op, rt, rd, dc, jmp, legal, urt);
        exp_jump = jmp && v && !fl && rn;
        for (int k = 0; k < 2; k++)
            exp_stall[k] = (k == 0) && v && rn && m_ex[k].mrd && m_ex[k].rw && (m_ex[k].wr != 0)
                           && ((m_ex[k].wr == rs) || (urt && (m_ex[k].wr == rt)));
        obs_jump[0] = id_jump;  obs_jump[1] = n_id_jump;
        obs_stall[0] = load_use_stall; obs_stall[1] = n_load_use_stall;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rn) begin
                m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_ill[k] = 0;
            end else begin
                take = v && !fl && !exp_stall[k];
                m_wb[k] = m_mem[k];
                m_mem[k] = m_ex[k];
                m_ex[k] = (take && legal) ? dc : '0;
                m_ill[k] = take && !legal;
            end
            exp_reg[k] = {m_ex[k].aluop, m_ex[k].alusrc, m_ex[k].shup, m_ex[k].beq, m_ex[k].bne,
                          m_mem[k].mrd, m_mem[k].mwr, m_wb[k].rw, m_wb[k].m2r, m_wb[k].wr, m_ill[k]};
        end
        #1;
        obs_reg[0] = {ex_alu_opcode, ex_alu_source, ex_shift_upper, ex_branch_eq, ex_branch_ne,
                      mem_memory_read, mem_memory_write, wb_register_write, wb_memory_to_register,
                      wb_write_reg, illegal_opcode};
        obs_reg[1] = {n_ex_alu_opcode, n_ex_alu_source, n_ex_shift_upper, n_ex_branch_eq, n_ex_branch_ne,
                      n_mem_memory_read, n_mem_memory_write, n_wb_register_write, n_wb_memory_to_register,
                      n_wb_write_reg, n_illegal_opcode};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, LW, 5'd1, 5'd2, 5'd3, 0, 0);
            checks++;
            if (obs_reg[0] !== 16'h0 || obs_stall[0] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%h stall=%b required=0000 stall=0", i, obs_reg[0], obs_stall[0]);
            end
        end
        cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, 1);
        checks++;
        if (obs_reg[0] !== 16'h0 || obs_reg[1] !== 16'h0) begin
            failures++;
            $display("FAIL reset_release_empty got=%h/%h required=0000", obs_reg[0], obs_reg[1]);
        end
    endtask

    task automatic test_stream();
        logic [5:0] ops[7] = '{RT, LW, SW, BEQ, RT, RT, RT};
        logic [4:0] rss[7] = '{5'd1, 5'd1, 5'd1, 5'd7, 5'd0, 5'd0, 5'd0};
        logic [4:0] rts[7] = '{5'd2, 5'd4, 5'd6, 5'd8, 5'd0, 5'd0, 5'd0};
        logic [1:0] alu_exp[4] = '{2'b10, 2'b00, 2'b00, 2'b01};
        for (int i = 0; i < 7; i++) begin
            cycle(i < 4, ops[i], rss[i], rts[i], (i == 0) ? 5'd3 : 5'd0, 0, 1);
            if (i < 4) begin
                checks++;
                if (ex_alu_opcode !== alu_exp[i]) begin
                    failures++;
                    $display("FAIL stream_ex_alu slot=%0d got=%b required=%b", i, ex_alu_opcode, alu_exp[i]);
                end
            end
            if (i == 2) begin
                checks++;
                if (mem_memory_read !== 1'b1 || wb_register_write !== 1'b1 || wb_write_reg !== 5'd3) begin
                    failures++;
                    $display("FAIL stream_lw_mem_add_wb got mrd=%b rw=%b wr=%0d required mrd=1 rw=1 wr=3",
                             mem_memory_read, wb_register_write, wb_write_reg);
                end
            end
            if (i == 3) begin
                checks++;
                if (wb_write_reg !== 5'd4 || wb_memory_to_register !== 1'b1 || mem_memory_write !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_lw_wb got wr=%0d m2r=%b mwr=%b required wr=4 m2r=1 mwr=1",
                             wb_write_reg, wb_memory_to_register, mem_memory_write);
                end
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (wb_register_write !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_no_write slot=%0d got=%b required=0", i, wb_register_write);
                end
            end
        end
    endtask

    task automatic test_load_use();
        cycle(1, LW, 5'd1, 5'd5, 5'd0, 0, 1);
        cycle(1, RT, 5'd5, 5'd2, 5'd9, 0, 1);
        checks++;
        if (obs_stall[0] !== 1'b1 || obs_stall[1] !== 1'b0 || ex_alu_opcode !== 2'b00
            || ex_alu_source !== 1'b0 || n_ex_alu_opcode !== 2'b10) begin
            failures++;
            $display("FAIL lu_stall_rs got stall=%b nh=%b ex_alu=%b nh_alu=%b required 1 0 00 10",
                     obs_stall[0], obs_stall[1], ex_alu_opcode, n_ex_alu_opcode);
        end
        cycle(1, RT, 5'd5, 5'd2, 5'd9, 0, 1);
        checks++;
        if (obs_stall[0] !== 1'b0 || ex_alu_opcode !== 2'b10) begin
            failures++;
            $display("FAIL lu_one_cycle got stall=%b ex_alu=%b required 0 10", obs_stall[0], ex_alu_opcode);
        end
        cycle(1, LW, 5'd1, 5'd5, 5'd0, 0, 1);
        cycle(1, SW, 5'd2, 5'd5, 5'd0, 0, 1);
        checks++;
        if (obs_stall[0] !== 1'b1 || obs_stall[1] !== 1'b0) begin
            failures++;
            $display("FAIL lu_stall_rt got=%b nh=%b required 1 0", obs_stall[0], obs_stall[1]);
        end
        cycle(1, SW, 5'd2, 5'd5, 5'd0, 0, 1);
        cycle(1, LW, 5'd3, 5'd0, 5'd0, 0, 1);
        cycle(1, RT, 5'd0, 5'd0, 5'd1, 0, 1);
        checks++;
        if (obs_stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL lu_reg0 got=%b required=0", obs_stall[0]);
        end
    endtask

    task automatic test_flush();
        cycle(1, ADDI, 5'd1, 5'd7, 5'd0, 1, 1);
        checks++;
        if (ex_alu_source !== 1'b0 || ex_alu_opcode !== 2'b00) begin
            failures++;
            $display("FAIL flush_ex_bubble got alusrc=%b alu=%b required 0 00", ex_alu_source, ex_alu_opcode);
        end
        cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, 1);
        cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, 1);
        checks++;
        if (wb_register_write !== 1'b0 || wb_write_reg !== 5'd0) begin
            failures++;
            $display("FAIL flush_no_wb got rw=%b wr=%0d required 0 0", wb_register_write, wb_write_reg);
        end
        cycle(1, JMP, 5'd0, 5'd0, 5'd0, 0, 1);
        checks++;
        if (obs_jump[0] !== 1'b1 || obs_jump[1] !== 1'b1) begin
            failures++;
            $display("FAIL jump_req got=%b/%b required=1", obs_jump[0], obs_jump[1]);
        end
        cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, 1);
        cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, 1);
        checks++;
        if (wb_register_write !== 1'b0) begin
            failures++;
            $display("FAIL jump_no_wb got=%b required=0", wb_register_write);
        end
        cycle(1, JMP, 5'd0, 5'd0, 5'd0, 1, 1);
        checks++;
        if (obs_jump[0] !== 1'b0) begin
            failures++;
            $display("FAIL jump_flushed got=%b required=0", obs_jump[0]);
        end
    endtask

    task automatic test_illegal();
        cycle(1, BAD, 5'd1, 5'd2, 5'd3, 0, 1);
        checks++;
        if (illegal_opcode !== 1'b1 || ex_alu_opcode !== 2'b00) begin
            failures++;
            $display("FAIL illegal_pulse got ill=%b alu=%b required 1 00", illegal_opcode, ex_alu_opcode);
        end
        cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, 1);
        checks++;
        if (illegal_opcode !== 1'b0 || mem_memory_read !== 1'b0 || mem_memory_write !== 1'b0) begin
            failures++;
            $display("FAIL illegal_one_cycle got ill=%b mrd=%b mwr=%b required 0 0 0",
                     illegal_opcode, mem_memory_read, mem_memory_write);
        end
        cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, 1);
        checks++;
        if (wb_register_write !== 1'b0) begin
            failures++;
            $display("FAIL illegal_no_wb got=%b required=0", wb_register_write);
        end
        cycle(1, BAD, 5'd1, 5'd2, 5'd3, 1, 1);
        checks++;
        if (illegal_opcode !== 1'b0) begin
            failures++;
            $display("FAIL illegal_flushed got=%b required=0", illegal_opcode);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1, LW, 5'd1, 5'd4, 5'd0, 0, 1);
        cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, 1);
        checks++;
        if (mem_memory_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_lw_in_mem got=%b required=1", mem_memory_read);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, RT, 5'd0, 5'd0, 5'd0, 0, (i == 0) ? 1'b0 : 1'b1);
            checks++;
            if (wb_register_write !== 1'b0 || wb_memory_to_register !== 1'b0 || mem_memory_read !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_discard cyc=%0d got rw=%b m2r=%b mrd=%b required 0 0 0",
                         i, wb_register_write, wb_memory_to_register, mem_memory_read);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] pool[10] = '{LW, SW, BEQ, BNE, ADDI, RT, LUI, ORI, JMP, BAD};
        logic [5:0] op;
        for (int i = 0; i < 500; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : pool[$urandom_range(0, 9)];
            cycle(($urandom_range(0, 7) != 0), op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) != 0));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_reg[k] !== exp_reg[k] || obs_jump[k] !== exp_jump || obs_stall[k] !== exp_stall[k]) begin
                    failures++;
                    $display("FAIL rand_dut%0d cyc=%0d got regs=%h jump=%b stall=%b required regs=%h jump=%b stall=%b",
                             k, i, obs_reg[k], obs_jump[k], obs_stall[k], exp_reg[k], exp_jump, exp_stall[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_ill[k] = 0;
        end
        test_reset();
        test_stream();
        test_load_use();
        test_flush();
        test_illegal();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
